// File: rtl/paint_write_scheduler.sv
// Pixel-write scheduler for a VGA framebuffer: arbitrates full-canvas clears and
// square brush stamps, emitting at most one registered pixel write per cycle.
module paint_write_scheduler #(
  parameter int unsigned SCREEN_WIDTH  = 320,
  parameter int unsigned SCREEN_HEIGHT = 240
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clear_req,
  input  logic [8:0] clear_color,
  input  logic       stamp_req,
  input  logic [8:0] stamp_x,
  input  logic [7:0] stamp_y,
  input  logic [8:0] stamp_color,
  input  logic [1:0] stamp_size,
  output logic       stamp_ack,
  output logic       clear_done,
  output logic       busy,
  output logic [8:0] vga_x,
  output logic [7:0] vga_y,
  output logic [8:0] vga_color,
  output logic       vga_write
);

  localparam logic [8:0]         XLast   = 9'(SCREEN_WIDTH - 1);
  localparam logic [7:0]         YLast   = 8'(SCREEN_HEIGHT - 1);
  localparam logic signed [11:0] WidthS  = 12'(SCREEN_WIDTH);
  localparam logic signed [11:0] HeightS = 12'(SCREEN_HEIGHT);

  typedef enum logic [1:0] {StIdle, StClear, StStamp} state_e;

  state_e     state_q;
  logic       clear_pending_q;
  logic [8:0] cx_q;
  logic [7:0] cy_q;
  logic [8:0] sx_q;
  logic [7:0] sy_q;
  logic [8:0] scolor_q;
  logic [1:0] sr_q;
  logic [2:0] dx_q, dy_q, dx_d, dy_d;

  logic              grant_clear, grant_stamp;
  logic [8:0]        base_x;
  logic [7:0]        base_y;
  logic [1:0]        base_r;
  logic [2:0]        span;
  logic              stamp_last, clear_last;
  logic signed [11:0] px, py;
  logic              on_canvas;

  always_comb begin
    grant_clear = (state_q == StIdle) && (clear_req || clear_pending_q);
    grant_stamp = (state_q == StIdle) && !grant_clear && stamp_req;
    // At the grant edge the sampled registers are not loaded yet, so use the inputs.
    base_x = grant_stamp ? stamp_x : sx_q;
    base_y = grant_stamp ? stamp_y : sy_q;
    base_r = grant_stamp ? stamp_size : sr_q;
    span   = {base_r, 1'b0};
    stamp_last = (dx_q == span) && (dy_q == span);
    clear_last = (cx_q == XLast) && (cy_q == YLast);

    dx_d = 3'd0;
    dy_d = 3'd0;
    if (!grant_stamp) begin
      if (dx_q == span) begin
        dy_d = dy_q + 3'd1;
      end else begin
        dx_d = dx_q + 3'd1;
        dy_d = dy_q;
      end
    end

    px = $signed({3'b0, base_x}) - $signed({10'b0, base_r}) + $signed({9'b0, dx_d});
    py = $signed({4'b0, base_y}) - $signed({10'b0, base_r}) + $signed({9'b0, dy_d});
    on_canvas = (px >= 12'sd0) && (px < WidthS) && (py >= 12'sd0) && (py < HeightS);
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q         <= StIdle;
      clear_pending_q <= 1'b0;
      cx_q            <= '0;
      cy_q            <= '0;
      dx_q            <= '0;
      dy_q            <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      scolor_q        <= '0;
      sr_q            <= '0;
      stamp_ack       <= 1'b0;
      clear_done      <= 1'b0;
      busy            <= 1'b0;
      vga_x           <= '0;
      vga_y           <= '0;
      vga_color       <= '0;
      vga_write       <= 1'b0;
    end else begin
      stamp_ack  <= 1'b0;
      clear_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          vga_write <= 1'b0;
          busy      <= 1'b0;
          if (grant_clear) begin
            state_q         <= StClear;
            clear_pending_q <= 1'b0;
            cx_q            <= '0;
            cy_q            <= '0;
            vga_x           <= '0;
            vga_y           <= '0;
            vga_color       <= clear_color;
            vga_write       <= 1'b1;
            busy            <= 1'b1;
          end else if (grant_stamp) begin
            state_q   <= StStamp;
            sx_q      <= stamp_x;
            sy_q      <= stamp_y;
            scolor_q  <= stamp_color;
            sr_q      <= stamp_size;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            stamp_ack <= 1'b1;
            busy      <= 1'b1;
            vga_write <= on_canvas;
            if (on_canvas) begin
              vga_x     <= px[8:0];
              vga_y     <= py[7:0];
              vga_color <= stamp_color;
            end
          end
        end
        StClear: begin
          if (clear_last) begin
            state_q    <= StIdle;
            vga_write  <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b1;
          end else if (cx_q == XLast) begin
            cx_q  <= '0;
            cy_q  <= cy_q + 8'd1;
            vga_x <= '0;
            vga_y <= cy_q + 8'd1;
          end else begin
            cx_q  <= cx_q + 9'd1;
            vga_x <= cx_q + 9'd1;
          end
        end
        StStamp: begin
          if (clear_req) clear_pending_q <= 1'b1;
          if (stamp_last) begin
            state_q   <= StIdle;
            vga_write <= 1'b0;
            busy      <= 1'b0;
          end else begin
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            vga_write <= on_canvas;
            if (on_canvas) begin
              vga_x     <= px[8:0];
              vga_y     <= py[7:0];
              vga_color <= scolor_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_paint_write_scheduler.sv
// Directed bench for paint_write_scheduler: a table of stamp cases plus hand-written
// clear, arbitration and mid-operation reset sequences.
module tb_paint_write_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clear_req = 1'b0;
  logic [8:0] clear_color = '0;
  logic       stamp_req = 1'b0;
  logic [8:0] stamp_x = '0;
  logic [7:0] stamp_y = '0;
  logic [8:0] stamp_color = '0;
  logic [1:0] stamp_size = '0;
  logic       stamp_ack, clear_done, busy, vga_write;
  logic [8:0] vga_x, vga_color;
  logic [7:0] vga_y;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  paint_write_scheduler #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(240)) dut (
    .CLOCK_50   (clk),
    .resetn     (resetn),
    .clear_req  (clear_req),
    .clear_color(clear_color),
    .stamp_req  (stamp_req),
    .stamp_x    (stamp_x),
    .stamp_y    (stamp_y),
    .stamp_color(stamp_color),
    .stamp_size (stamp_size),
    .stamp_ack  (stamp_ack),
    .clear_done (clear_done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_color  (vga_color),
    .vga_write  (vga_write)
  );

  typedef struct {
    int x, y, r, color;
    int cycles, writes;
    int fx, fy, lx, ly;
  } stamp_vec_t;

  stamp_vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_stamp(input stamp_vec_t v);
    int busy_n, wr_n, ack_n, pos_err, col_err, fx, fy, lx, ly, k, side, ex, ey;
    bit done, on;
    busy_n = 0; wr_n = 0; ack_n = 0; pos_err = 0; col_err = 0;
    fx = -1; fy = -1; lx = -1; ly = -1; k = 0; done = 0;
    side = 2 * v.r + 1;
    @(negedge clk);
    stamp_x = 9'(v.x); stamp_y = 8'(v.y); stamp_color = 9'(v.color);
    stamp_size = 2'(v.r); stamp_req = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (stamp_ack) begin
        ack_n++;
        stamp_req = 1'b0;
      end
      if (busy) begin
        ex = v.x - v.r + (k % side);
        ey = v.y - v.r + (k / side);
        on = (ex >= 0) && (ex < 320) && (ey >= 0) && (ey < 240);
        if (vga_write !== on) pos_err++;
        if (vga_write) begin
          wr_n++;
          if (vga_x != ex || vga_y != ey) pos_err++;
          if (vga_color != v.color) col_err++;
          if (wr_n == 1) begin fx = vga_x; fy = vga_y; end
          lx = vga_x; ly = vga_y;
        end
        k++;
        busy_n++;
      end else if (busy_n > 0) begin
        done = 1;
      end
    end
    stamp_req = 1'b0;
    check("stamp_finished", int'(done), 1);
    check("stamp_busy_cycles", busy_n, v.cycles);
    check("stamp_writes", wr_n, v.writes);
    check("stamp_acks", ack_n, 1);
    check("stamp_first_x", fx, v.fx);
    check("stamp_first_y", fy, v.fy);
    check("stamp_last_x", lx, v.lx);
    check("stamp_last_y", ly, v.ly);
    check("stamp_position_errors", pos_err, 0);
    check("stamp_color_errors", col_err, 0);
    check("stamp_idle_write", int'(vga_write), 0);
  endtask

  initial begin
    int busy_n, wr, bad, ack_during;
    bit done;

    vecs[0] = '{x:100, y:50,  r:1, color:'h1FF, cycles:9,  writes:9,  fx:99,  fy:49,  lx:101, ly:51};
    vecs[1] = '{x:0,   y:0,   r:2, color:'h0C3, cycles:25, writes:9,  fx:0,   fy:0,   lx:2,   ly:2};
    vecs[2] = '{x:319, y:239, r:3, color:'h155, cycles:49, writes:16, fx:316, fy:236, lx:319, ly:239};
    vecs[3] = '{x:10,  y:10,  r:0, color:'h0AA, cycles:1,  writes:1,  fx:10,  fy:10,  lx:10,  ly:10};
    vecs[4] = '{x:320, y:100, r:1, color:'h007, cycles:9,  writes:3,  fx:319, fy:99,  lx:319, ly:101};
    vecs[5] = '{x:5,   y:239, r:2, color:'h1C0, cycles:25, writes:15, fx:3,   fy:237, lx:7,   ly:239};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_vga_write", int'(vga_write), 0);
    check("reset_stamp_ack", int'(stamp_ack), 0);
    check("reset_clear_done", int'(clear_done), 0);
    check("reset_vga_x", int'(vga_x), 0);
    check("reset_vga_y", int'(vga_y), 0);
    check("reset_vga_color", int'(vga_color), 0);
    resetn = 1'b1;

    for (int i = 0; i < 6; i++) run_stamp(vecs[i]);

    // Clear and stamp requested together: clear first, stray clear_req mid-clear ignored
    @(negedge clk);
    clear_color = 9'h000; clear_req = 1'b1;
    stamp_x = 9'd7; stamp_y = 8'd7; stamp_size = 2'd0; stamp_color = 9'h123; stamp_req = 1'b1;
    busy_n = 0; wr = 0; bad = 0; ack_during = 0; done = 0;
    for (int c = 0; c < 80000 && !done; c++) begin
      @(negedge clk);
      if (busy) begin
        if (!vga_write || vga_x != (wr % 320) || vga_y != (wr / 320) || vga_color != 0) bad++;
        if (stamp_ack) ack_during++;
        wr++;
        busy_n++;
      end else if (busy_n > 0) begin
        done = 1;
      end
      clear_req = (busy_n == 500);
    end
    clear_req = 1'b0;
    check("clear_finished", int'(done), 1);
    check("clear_busy_cycles", busy_n, 76800);
    check("clear_raster_errors", bad, 0);
    check("clear_ack_during", ack_during, 0);
    check("clear_done_pulse", int'(clear_done), 1);
    check("clear_idle_write", int'(vga_write), 0);
    check("clear_hold_x", int'(vga_x), 319);
    check("clear_hold_y", int'(vga_y), 239);
    check("clear_idle_ack", int'(stamp_ack), 0);
    @(negedge clk);
    check("post_clear_stamp_ack", int'(stamp_ack), 1);
    check("post_clear_done_low", int'(clear_done), 0);
    check("post_clear_stamp_x", int'(vga_x), 7);
    stamp_req = 1'b0;
    @(negedge clk);
    check("post_clear_stamp_end", int'(busy), 0);

    // clear_req pulsed mid-stamp, then reset on clear write 1000
    @(negedge clk);
    stamp_x = 9'd100; stamp_y = 8'd50; stamp_size = 2'd2; stamp_color = 9'h0F0;
    clear_color = 9'h1AB; stamp_req = 1'b1;
    busy_n = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stamp_ack) stamp_req = 1'b0;
      if (busy) busy_n++;
      else if (busy_n > 0) done = 1;
      clear_req = (busy_n == 5);
    end
    clear_req = 1'b0;
    stamp_req = 1'b0;
    check("pend_stamp_cycles", busy_n, 25);
    check("pend_idle_busy", int'(busy), 0);
    check("pend_idle_done", int'(clear_done), 0);
    @(negedge clk);
    check("pend_clear_busy", int'(busy), 1);
    check("pend_clear_write", int'(vga_write), 1);
    check("pend_clear_x0", int'(vga_x), 0);
    check("pend_clear_y0", int'(vga_y), 0);
    check("pend_clear_color", int'(vga_color), 'h1AB);
    wr = 1;
    for (int c = 0; c < 2000 && wr < 1000; c++) begin
      @(negedge clk);
      if (vga_write) wr++;
    end
    check("pend_write_count", wr, 1000);
    check("pend_write1000_x", int'(vga_x), 39);
    check("pend_write1000_y", int'(vga_y), 3);
    resetn = 1'b0;
    @(negedge clk);
    check("abort_write", int'(vga_write), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(clear_done), 0);
    check("abort_vga_x", int'(vga_x), 0);
    resetn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("after_reset_busy", int'(busy), 0);
    check("after_reset_done", int'(clear_done), 0);
    check("after_reset_write", int'(vga_write), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
